pc_next_unit: RTL and testbench

- Parametrised successor to the combinational jump-select mux.
- Owns the architectural PC register of the pipelined CPU and selects the next PC from sequential, branch, jump-immediate, jump-register and exception sources.
- Adds stall hold, a pending-redirect latch (a redirect arriving during a stall is not lost), exception priority, and an illegal-select flag.
- Sits at the IF stage; its outputs feed instruction memory and the IF/ID register.

---
 rtl/pc_next_unit_pkg.sv | 14 +
 rtl/pc_next_unit_target_decode.sv | 36 +++
 rtl/pc_next_unit.sv | 90 +++++++++
 tb/tb_pc_next_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared next-PC select encodings and default PC constants.
// Codes J, JR and RSV ignore sel[0]; only their upper two bits are compared.
package pc_next_unit_pkg;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b100;
  localparam logic [2:0] SEL_RSV = 3'b110;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_next_unit_target_decode.sv
// Combinational next-PC target mux: sel to target, redirect flag and reserved-code flag.
// Zero latency, no flow control; every sel code maps to a defined output.
module pc_target_decode
  import pc_next_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] seq_target,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] target,
  output logic             redirect,
  output logic             illegal
);

  always_comb begin
    target   = seq_target;
    redirect = 1'b0;
    illegal  = 1'b0;
    if (sel == SEL_BR) begin
      target   = branch_target;
      redirect = 1'b1;
    end else if (sel[2:1] == SEL_J[2:1]) begin
      target   = jump_target;
      redirect = 1'b1;
    end else if (sel[2:1] == SEL_JR[2:1]) begin
      target   = jr_target;
      redirect = 1'b1;
    end else if (sel[2:1] == SEL_RSV[2:1]) begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with stall hold, pending-redirect latch and exception priority.
// New PC appears one cycle after selection; a redirect seen while stalled is replayed once stall clears.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               PC_INC     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             redirect_pending,
  output logic             illegal_sel
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             illegal_q;

  logic [WIDTH-1:0] dec_target;
  logic             dec_redirect;
  logic             dec_illegal;

  assign pc_plus_inc = pc_q + WIDTH'(PC_INC);

  pc_target_decode #(.WIDTH(WIDTH)) u_decode (
    .sel           (sel),
    .seq_target    (pc_plus_inc),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .target        (dec_target),
    .redirect      (dec_redirect),
    .illegal       (dec_illegal)
  );

  always_comb begin
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_vld_d = pend_vld_q;
    if (exc_req) begin
      pc_d       = EXC_VECTOR;
      pend_tgt_d = '0;
      pend_vld_d = 1'b0;
    end else if (stall) begin
      // Latest redirect wins if several arrive during one stall.
      if (dec_redirect) begin
        pend_tgt_d = dec_target;
        pend_vld_d = 1'b1;
      end
    end else if (dec_redirect) begin
      pc_d       = dec_target;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      pc_d       = pend_tgt_q;
      pend_vld_d = 1'b0;
    end else begin
      pc_d = pc_plus_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_vld_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_vld_q <= pend_vld_d;
      illegal_q  <= dec_illegal;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = pend_vld_q;
  assign illegal_sel      = illegal_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit with hand-computed expected values.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        redirect_pending;
  logic        illegal_sel;

  int n_cmp = 0;
  int n_err = 0;

  pc_next_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .sel              (sel),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .jr_target        (jr_target),
    .exc_req          (exc_req),
    .pc               (pc),
    .pc_plus_inc      (pc_plus_inc),
    .redirect_pending (redirect_pending),
    .illegal_sel      (illegal_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] e_pc, input logic e_rp, input logic e_ill);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".rp"}, {31'd0, redirect_pending}, {31'd0, e_rp});
    chk({tag, ".ill"}, {31'd0, illegal_sel}, {31'd0, e_ill});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; sel = 3'b000; exc_req = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0;
    step();
    chk3("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.inc", pc_plus_inc, 32'h4);

    // Sequential run
    rst = 1'b0;
    step(); chk3("seq1", 32'h4, 1'b0, 1'b0);
    step(); chk3("seq2", 32'h8, 1'b0, 1'b0);
    step(); chk3("seq3", 32'hC, 1'b0, 1'b0);
    step(); chk("seq4.pc", pc, 32'h10);

    // Branch during a two-cycle stall is replayed afterwards
    sel = 3'b001; branch_target = 32'h40; stall = 1'b1;
    step(); chk3("stall1", 32'h10, 1'b1, 1'b0);
    step(); chk3("stall2", 32'h10, 1'b1, 1'b0);
    sel = 3'b000; stall = 1'b0;
    step(); chk3("replay", 32'h40, 1'b0, 1'b0);

    // Live jr beats pending jump
    sel = 3'b010; jump_target = 32'h80; stall = 1'b1;
    step(); chk3("jpend", 32'h40, 1'b1, 1'b0);
    sel = 3'b100; jr_target = 32'hC0; stall = 1'b0;
    step(); chk3("live", 32'hC0, 1'b0, 1'b0);

    // Exception overrides stall and discards pending target
    sel = 3'b001; branch_target = 32'h200; stall = 1'b1;
    step(); chk3("pend_exc", 32'hC0, 1'b1, 1'b0);
    sel = 3'b000; exc_req = 1'b1;
    step(); chk3("exc", 32'h4180, 1'b0, 1'b0);
    exc_req = 1'b0; stall = 1'b0;
    step(); chk3("post_exc", 32'h4184, 1'b0, 1'b0);

    // Wrap-around
    sel = 3'b101; jr_target = 32'hFFFF_FFFC;
    step(); chk3("top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("top.inc", pc_plus_inc, 32'h0);
    sel = 3'b000;
    step(); chk3("wrap", 32'h0, 1'b0, 1'b0);

    // Reserved selects
    sel = 3'b011; jump_target = 32'h20;
    step(); chk3("j20", 32'h20, 1'b0, 1'b0);
    sel = 3'b110;
    step(); chk3("rsv110", 32'h24, 1'b0, 1'b1);
    sel = 3'b000;
    step(); chk3("rsv_clr", 32'h28, 1'b0, 1'b0);
    sel = 3'b111; stall = 1'b1;
    step(); chk3("rsv111_stall", 32'h28, 1'b0, 1'b1);
    sel = 3'b000; stall = 1'b0;
    step(); chk3("rsv_clr2", 32'h2C, 1'b0, 1'b0);

    // Reset wins over stall, pending redirect and reserved select
    sel = 3'b010; jump_target = 32'h300; stall = 1'b1;
    step(); chk3("pend_rst", 32'h2C, 1'b1, 1'b0);
    rst = 1'b1; sel = 3'b110;
    step(); chk3("rst_mid", 32'h0, 1'b0, 1'b0);
    rst = 1'b0; sel = 3'b000; stall = 1'b0;
    step(); chk3("after_rst", 32'h4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
